// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core. It detects load-use hazards,
// inserts bubbles on a stall or an EX flush, and counts stalls and flushes.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [4:0]        id_rs_addr,
    input  logic [4:0]        id_rt_addr,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm_ext,
    input  logic [4:0]        id_shamt,
    input  logic [5:0]        id_funct,
    input  logic [4:0]        id_wr_addr,
    input  logic              id_branch,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic [1:0]        id_memtoreg,
    input  logic              id_alusrc1,
    input  logic              id_alusrc2,
    input  logic [3:0]        id_aluop,
    input  logic              flush_ex,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [4:0]        ex_rs_addr,
    output logic [4:0]        ex_rt_addr,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm_ext,
    output logic [4:0]        ex_shamt,
    output logic [5:0]        ex_funct,
    output logic [4:0]        ex_wr_addr,
    output logic              ex_branch,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic [1:0]        ex_memtoreg,
    output logic              ex_alusrc1,
    output logic              ex_alusrc2,
    output logic [3:0]        ex_aluop,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] pcPlus4;
        logic [DATA_W-1:0] rsData;
        logic [DATA_W-1:0] rtData;
        logic [DATA_W-1:0] immExt;
        logic [4:0]        rsAddr;
        logic [4:0]        rtAddr;
        logic [4:0]        shamt;
        logic [4:0]        wrAddr;
        logic [5:0]        funct;
        logic              branch;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic [1:0]        memtoreg;
        logic              alusrc1;
        logic              alusrc2;
        logic [3:0]        aluop;
    } bundle_t;

    bundle_t    idBundle;
    bundle_t    exBundleReg;
    logic       exValidReg;
    logic       loadUse;
    logic [1:0] cntInc;
    logic [2*CNT_W-1:0] cntFlat;

    // An invalid ID slot still carries its fields, but its side-effecting enables are cleared.
    always_comb begin
        idBundle          = '0;
        idBundle.pcPlus4  = id_pc_plus4;
        idBundle.rsData   = id_rs_data;
        idBundle.rtData   = id_rt_data;
        idBundle.immExt   = id_imm_ext;
        idBundle.rsAddr   = id_rs_addr;
        idBundle.rtAddr   = id_rt_addr;
        idBundle.shamt    = id_shamt;
        idBundle.wrAddr   = id_wr_addr;
        idBundle.funct    = id_funct;
        idBundle.branch   = id_branch   & id_valid;
        idBundle.regwrite = id_regwrite & id_valid;
        idBundle.memread  = id_memread  & id_valid;
        idBundle.memwrite = id_memwrite & id_valid;
        idBundle.memtoreg = id_memtoreg;
        idBundle.alusrc1  = id_alusrc1;
        idBundle.alusrc2  = id_alusrc2;
        idBundle.aluop    = id_aluop;
    end

    always_comb begin
        loadUse = id_valid && exValidReg && exBundleReg.memread &&
                  (exBundleReg.wrAddr != 5'd0) &&
                  ((id_uses_rs && (id_rs_addr == exBundleReg.wrAddr)) ||
                   (id_uses_rt && (id_rt_addr == exBundleReg.wrAddr)));
    end

    assign stall = loadUse && !flush_ex;

    always_ff @(posedge clk) begin
        if (reset) begin
            exBundleReg <= '0;
            exValidReg  <= 1'b0;
        end else if (flush_ex || loadUse) begin
            exBundleReg <= '0;
            exValidReg  <= 1'b0;
        end else begin
            exBundleReg <= idBundle;
            exValidReg  <= id_valid;
        end
    end

    assign cntInc[0] = stall;
    assign cntInc[1] = flush_ex;

    // Saturating event counters: index 0 counts stalls, index 1 counts flushes.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
            logic [CNT_W-1:0] cntReg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    cntReg <= '0;
                end else if (cntInc[gi] && (cntReg != {CNT_W{1'b1}})) begin
                    cntReg <= cntReg + 1'b1;
                end
            end
            assign cntFlat[gi*CNT_W +: CNT_W] = cntReg;
        end
    endgenerate

    assign stall_cnt = cntFlat[0 +: CNT_W];
    assign flush_cnt = cntFlat[CNT_W +: CNT_W];

    assign ex_valid    = exValidReg;
    assign ex_pc_plus4 = exBundleReg.pcPlus4;
    assign ex_rs_addr  = exBundleReg.rsAddr;
    assign ex_rt_addr  = exBundleReg.rtAddr;
    assign ex_rs_data  = exBundleReg.rsData;
    assign ex_rt_data  = exBundleReg.rtData;
    assign ex_imm_ext  = exBundleReg.immExt;
    assign ex_shamt    = exBundleReg.shamt;
    assign ex_funct    = exBundleReg.funct;
    assign ex_wr_addr  = exBundleReg.wrAddr;
    assign ex_branch   = exBundleReg.branch;
    assign ex_regwrite = exBundleReg.regwrite;
    assign ex_memread  = exBundleReg.memread;
    assign ex_memwrite = exBundleReg.memwrite;
    assign ex_memtoreg = exBundleReg.memtoreg;
    assign ex_alusrc1  = exBundleReg.alusrc1;
    assign ex_alusrc2  = exBundleReg.alusrc2;
    assign ex_aluop    = exBundleReg.aluop;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and random test of id_ex_stage with a 4-bit counter build so saturation is reachable.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, id_valid, id_uses_rs, id_uses_rt, flush_ex;
    logic [DATA_W-1:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext;
    logic [4:0]        id_rs_addr, id_rt_addr, id_shamt, id_wr_addr;
    logic [5:0]        id_funct;
    logic              id_branch, id_regwrite, id_memread, id_memwrite;
    logic [1:0]        id_memtoreg;
    logic              id_alusrc1, id_alusrc2;
    logic [3:0]        id_aluop;

    logic              stall, ex_valid;
    logic [DATA_W-1:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
    logic [4:0]        ex_rs_addr, ex_rt_addr, ex_shamt, ex_wr_addr;
    logic [5:0]        ex_funct;
    logic              ex_branch, ex_regwrite, ex_memread, ex_memwrite;
    logic [1:0]        ex_memtoreg;
    logic              ex_alusrc1, ex_alusrc2;
    logic [3:0]        ex_aluop;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc_plus4(id_pc_plus4),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm_ext(id_imm_ext), .id_shamt(id_shamt), .id_funct(id_funct),
        .id_wr_addr(id_wr_addr), .id_branch(id_branch), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2), .id_aluop(id_aluop),
        .flush_ex(flush_ex), .stall(stall), .ex_valid(ex_valid),
        .ex_pc_plus4(ex_pc_plus4), .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext),
        .ex_shamt(ex_shamt), .ex_funct(ex_funct), .ex_wr_addr(ex_wr_addr),
        .ex_branch(ex_branch), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_alusrc1(ex_alusrc1),
        .ex_alusrc2(ex_alusrc2), .ex_aluop(ex_aluop), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc, rsData, rtData, imm;
        logic [4:0]        rs, rt, shamt, wr;
        logic [5:0]        funct;
        logic              branch, regwrite, memread, memwrite;
        logic [1:0]        memtoreg;
        logic              alusrc1, alusrc2;
        logic [3:0]        aluop;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   started = 0;

    // Reference state: what EX should hold after the last edge, plus counters.
    logic             mValid = 1'b0, mMemread = 1'b0;
    logic [4:0]       mWr = 5'd0;
    logic [CNT_W-1:0] mSc = '0, mFc = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] x);
        return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
    endfunction

    task automatic setInstr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic ur, input logic ut, input logic [4:0] wr,
                            input logic mr);
        id_valid    = v;
        id_pc_plus4 = $urandom;
        id_rs_data  = $urandom;
        id_rt_data  = $urandom;
        id_imm_ext  = $urandom;
        id_rs_addr  = rs;
        id_rt_addr  = rt;
        id_uses_rs  = ur;
        id_uses_rt  = ut;
        id_shamt    = 5'($urandom);
        id_funct    = 6'($urandom);
        id_wr_addr  = wr;
        id_memread  = mr;
        id_regwrite = mr ? 1'b1 : 1'($urandom);
        id_memwrite = mr ? 1'b0 : 1'($urandom);
        id_branch   = 1'($urandom);
        id_memtoreg = mr ? 2'b01 : 2'($urandom_range(0, 2));
        id_alusrc1  = 1'($urandom);
        id_alusrc2  = 1'($urandom);
        id_aluop    = 4'($urandom);
    endtask

    // One clock: check the combinational stall, queue the expected EX contents,
    // then compare them after the edge.
    task automatic step(input string tag);
        exp_t e, o;
        logic lu, expStall;
        #1;
        lu = id_valid && mValid && mMemread && (mWr != 5'd0) &&
             ((id_uses_rs && id_rs_addr == mWr) || (id_uses_rt && id_rt_addr == mWr));
        expStall = lu && !flush_ex;
        if (started) chk({tag, ".stall"}, 256'(stall), 256'(expStall));
        e = '0;
        if (reset) begin
            mSc = '0;
            mFc = '0;
        end else if (flush_ex) begin
            mFc = sat(mFc);
        end else if (lu) begin
            mSc = sat(mSc);
        end else begin
            e.valid    = id_valid;
            e.pc       = id_pc_plus4;
            e.rsData   = id_rs_data;
            e.rtData   = id_rt_data;
            e.imm      = id_imm_ext;
            e.rs       = id_rs_addr;
            e.rt       = id_rt_addr;
            e.shamt    = id_shamt;
            e.wr       = id_wr_addr;
            e.funct    = id_funct;
            e.branch   = id_branch & id_valid;
            e.regwrite = id_regwrite & id_valid;
            e.memread  = id_memread & id_valid;
            e.memwrite = id_memwrite & id_valid;
            e.memtoreg = id_memtoreg;
            e.alusrc1  = id_alusrc1;
            e.alusrc2  = id_alusrc2;
            e.aluop    = id_aluop;
        end
        expQ.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        started = 1;
        e = expQ.pop_front();
        o = {ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext, ex_rs_addr,
             ex_rt_addr, ex_shamt, ex_wr_addr, ex_funct, ex_branch, ex_regwrite,
             ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc1, ex_alusrc2, ex_aluop};
        chk({tag, ".ex"}, 256'(o), 256'(e));
        chk({tag, ".stall_cnt"}, 256'(stall_cnt), 256'(mSc));
        chk({tag, ".flush_cnt"}, 256'(flush_cnt), 256'(mFc));
        mValid   = e.valid;
        mMemread = e.memread;
        mWr      = e.wr;
        $display("cyc %0d %s: ex_valid=%0b ex_wr=%0d ex_memread=%0b stall_cnt=%0d flush_cnt=%0d",
                 cyc, tag, ex_valid, ex_wr_addr, ex_memread, stall_cnt, flush_cnt);
    endtask

    initial begin
        reset = 1'b1;
        flush_ex = 1'b0;
        setInstr(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1);
        step("reset0");
        step("reset1");
        reset = 1'b0;
        step("capture");

        // Load-use on rs: one stall, bubble, then the add enters EX.
        setInstr(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1);
        step("lw8");
        setInstr(1'b1, 5'd8, 5'd2, 1'b1, 1'b1, 5'd10, 1'b0);
        step("lu_stall");
        step("lu_release");

        // $0 destination and an unused rt never stall.
        setInstr(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1);
        step("lw0");
        setInstr(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b0);
        step("use0");
        setInstr(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1);
        step("lw8b");
        setInstr(1'b1, 5'd3, 5'd8, 1'b1, 1'b0, 5'd12, 1'b0);
        step("rt_unused");

        // Hazard plus flush in the same cycle: flush wins.
        setInstr(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1);
        step("lw8c");
        setInstr(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd13, 1'b0);
        flush_ex = 1'b1;
        step("flush_hz");
        flush_ex = 1'b0;
        step("after_flush");

        // Back-to-back dependent loads, then a consumer of the second.
        setInstr(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1);
        step("lwA");
        setInstr(1'b1, 5'd8, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1);
        step("lwB_stall");
        step("lwB_enter");
        setInstr(1'b1, 5'd4, 5'd9, 1'b1, 1'b1, 5'd14, 1'b0);
        step("use9_stall");
        step("use9_enter");

        // Reset in the middle of a stall; the held instruction re-enters afterwards.
        setInstr(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1);
        step("lwR");
        setInstr(1'b1, 5'd8, 5'd2, 1'b1, 1'b0, 5'd15, 1'b0);
        reset = 1'b1;
        step("reset_mid");
        reset = 1'b0;
        step("reenter");

        // Stall counter saturation: lw $8,0($8) repeatedly stalls on itself.
        setInstr(1'b1, 5'd8, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1);
        for (int i = 0; i < 2 * ((1 << CNT_W) + 5); i++) step("stall_sat");

        // Flush counter saturation.
        flush_ex = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 5; i++) step("flush_sat");
        flush_ex = 1'b0;

        // Random traffic over a small register set to provoke hazards.
        reset = 1'b1;
        step("reset_rand");
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            logic [4:0] regs [4];
            regs = '{5'd0, 5'd8, 5'd9, 5'd17};
            setInstr(1'($urandom_range(0, 4) != 0), regs[$urandom_range(0, 3)],
                     regs[$urandom_range(0, 3)], 1'($urandom), 1'($urandom),
                     regs[$urandom_range(0, 3)], 1'($urandom));
            flush_ex = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 49) == 0);
            step("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage MIPS core; sits directly downstream of the instruction decoder/control unit.
- Registers the decoded control bundle and operands into EX.
- Detects load-use hazards, raises a stall and inserts a bubble.
- Applies branch/jump flushes from EX.
- Keeps saturating stall/flush performance counters.

Parameters:
DATA_W, 32, datapath width (PC, register data, immediate)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_pc_plus4  in  DATA_W  PC+4 of ID instruction
id_rs_addr  in  5  rs field
id_rt_addr  in  5  rt field
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_rs_data  in  DATA_W  register-file read of rs
id_rt_data  in  DATA_W  register-file read of rt
id_imm_ext  in  DATA_W  extended/lui-shifted immediate
id_shamt  in  5  shift amount
id_funct  in  6  funct field
id_wr_addr  in  5  destination register, already RegDst-selected
id_branch  in  1  conditional branch
id_regwrite  in  1  register write enable
id_memread  in  1  load
id_memwrite  in  1  store
id_memtoreg  in  2  writeback select (00 ALU, 01 mem, 10 PC+4)
id_alusrc1  in  1  ALU A = shamt
id_alusrc2  in  1  ALU B = immediate
id_aluop  in  4  ALU operation class
flush_ex  in  1  EX resolved a taken branch/jump; kill the ID instruction
stall  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  EX holds a real instruction
ex_<field>  out  same as id_<field>  registered copy of every id_ input above except id_valid, id_uses_rs, id_uses_rt
stall_cnt  out  CNT_W  cycles with stall asserted
flush_cnt  out  CNT_W  cycles with a flush bubble inserted

Behaviour:
- Reset: every ex_* output, ex_valid, stall_cnt and flush_cnt is 0; stall is 0 because ex_valid = 0.
- Load-use hazard, combinational from ID inputs and EX registers. All of these must hold:
  - id_valid = 1.
  - ex_valid = 1 and ex_memread = 1.
  - ex_wr_addr != 0.
  - (id_uses_rs and id_rs_addr == ex_wr_addr) or (id_uses_rt and id_rt_addr == ex_wr_addr).
- stall = load_use AND NOT flush_ex. A flushed instruction never stalls.
- Per rising edge, priority reset > flush_ex > load_use > normal:
  - flush_ex = 1: bubble. ex_valid = 0, all ex_* fields = 0; flush_cnt += 1.
  - load_use = 1: bubble, same as flush; stall_cnt += 1. The upstream instruction is held, so it re-presents next cycle.
  - Otherwise: ex_* ← id_*, ex_valid ← id_valid.
    - id_valid = 0 is loaded as a bubble: ex_valid = 0 and all control enables zeroed.
- Bubble invariant: whenever ex_valid = 0, ex_regwrite, ex_memread, ex_memwrite and ex_branch are 0.
- Load-use stall lasts exactly 1 cycle; the bubble clears ex_memread. Back-to-back loads feeding each other give one stall per pair.
- $0 destination never causes a stall.
- Latency: ID→EX is 1 cycle; stall is combinational, 0 cycles.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Reset asserted mid-stall: next cycle ex_valid = 0 and counters = 0. The held instruction re-enters normally after reset deasserts.

Test Plan:
- Reset with id_valid = 1 and random fields → all ex_* = 0, stall = 0, counters 0; the following cycle the bundle is captured unchanged.
- lw $8 in EX (ex_wr_addr = 8), ID add with rs = 8, uses_rs = 1 → stall = 1 for exactly one cycle, ex_valid = 0 next, stall_cnt = 1; the add then enters EX with stall = 0.
- lw to $0 in EX, ID uses rs = 0 → stall = 0, no bubble. ID rt = 8 with uses_rt = 0 → no stall.
- Hazard condition plus flush_ex = 1 in the same cycle → stall = 0, bubble, flush_cnt = 1, stall_cnt unchanged.
- Hold hazard/flush condition for 2^CNT_W+5 cycles with CNT_W = 4 → counter reads 15 and stays 15.
